kd_tree_root_ctrl: RTL and testbench

// Host-side command initiator that drives the top port of the kd-tree root node.

---
 rtl/kd_tree_root_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_kd_tree_root_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kd_tree_root_ctrl.sv
// rtl/kd_tree_root_ctrl.sv - host-side build-pass sequencer for the kd-tree root node
//
// Purpose: drives the root node's top port through one build pass
//   (tree reset, center streaming, sort-axis configuration, sort start),
//   waits on the root's response codes, and reports done / error / root center.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start, axis           pass request and initial sort axis (sampled on accept)
//   center_in*            host center stream (valid/ready handshake)
//   data/command_to_root  registered command channel toward the root node
//   data/command_from_root response channel from the root node
//   busy, done, error     pass status (done is a 1-cycle pulse, error is sticky)
//   root_center           root center captured when the sort settles
//   state_out             current state encoding
module kd_tree_root_ctrl #(
  parameter int DATA_W        = 24,
  parameter int CMD_W         = 5,
  parameter int N_CENTERS     = 7,
  parameter int AXIS_W        = 2,
  parameter int TIMEOUT       = 1000,
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AXIS_W-1:0] axis,
  input  logic [DATA_W-1:0] center_in,
  input  logic              center_in_valid,
  output logic              center_in_ready,
  output logic [DATA_W-1:0] data_to_root,
  output logic [CMD_W-1:0]  command_to_root,
  input  logic [DATA_W-1:0] data_from_root,
  input  logic [CMD_W-1:0]  command_from_root,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] root_center,
  output logic [2:0]        state_out
);

  localparam int TO_W   = $clog2(TIMEOUT) + 1;
  localparam int FILL_W = $clog2(N_CENTERS + 1);
  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);

  localparam logic [CMD_W-1:0] CMD_NOP       = CMD_W'(5'h00);
  localparam logic [CMD_W-1:0] CMD_FILL      = CMD_W'(5'h01);
  localparam logic [CMD_W-1:0] CMD_AXIS      = CMD_W'(5'h02);
  localparam logic [CMD_W-1:0] CMD_FILL_DONE = CMD_W'(5'h05);
  localparam logic [CMD_W-1:0] CMD_AXIS_DONE = CMD_W'(5'h07);
  localparam logic [CMD_W-1:0] CMD_SORT      = CMD_W'(5'h09);
  localparam logic [CMD_W-1:0] CMD_RTS       = CMD_W'(5'h0A);
  localparam logic [CMD_W-1:0] CMD_RST_DONE  = CMD_W'(5'h1E);
  localparam logic [CMD_W-1:0] CMD_RST       = CMD_W'(5'h1F);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RST   = 3'd1;
  localparam logic [2:0] S_FILL  = 3'd2;
  localparam logic [2:0] S_FILLW = 3'd3;
  localparam logic [2:0] S_AXIS  = 3'd4;
  localparam logic [2:0] S_SORT  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [AXIS_W-1:0] axis_q, axis_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [DATA_W-1:0] root_q, root_d;
  logic              ready_q, ready_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;

  logic accept;
  logic timed_out;
  logic waiting;

  // The handshake uses the registered ready, so the accept that completes
  // the N-th center also clears ready on the same edge.
  assign accept    = (state_q == S_FILL) && center_in_valid && ready_q;
  assign timed_out = (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign waiting   = (state_q == S_RST) || (state_q == S_FILLW) ||
                     (state_q == S_AXIS) || (state_q == S_SORT);

  always_comb begin
    state_d    = state_q;
    axis_d     = axis_q;
    error_d    = error_q;
    root_d     = root_q;
    done_d     = 1'b0;
    fill_cnt_d = fill_cnt_q;
    stab_cnt_d = stab_cnt_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          axis_d     = axis;
          error_d    = 1'b0;
          fill_cnt_d = '0;
          stab_cnt_d = '0;
          state_d    = S_RST;
        end
      end
      S_RST: begin
        if (command_from_root == CMD_RST_DONE) begin
          state_d = S_FILL;
        end else if (timed_out) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end
      end
      S_FILL: begin
        if (accept) begin
          fill_cnt_d = fill_cnt_q + FILL_W'(1);
          if (fill_cnt_q == FILL_W'(N_CENTERS - 1)) begin
            state_d = S_FILLW;
          end
        end
      end
      S_FILLW: begin
        if (command_from_root == CMD_FILL_DONE) begin
          state_d = S_AXIS;
        end else if (timed_out) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end
      end
      S_AXIS: begin
        if (command_from_root == CMD_AXIS_DONE) begin
          state_d = S_SORT;
        end else if (timed_out) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end
      end
      S_SORT: begin
        // Any response other than ready_to_sort (busy included) restarts
        // the stability window.
        if (command_from_root == CMD_RTS) begin
          stab_cnt_d = stab_cnt_q + STAB_W'(1);
        end else begin
          stab_cnt_d = '0;
        end
        if (stab_cnt_d == STAB_W'(STABLE_CYCLES)) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          root_d     = data_from_root;
          stab_cnt_d = '0;
        end else if (timed_out) begin
          state_d = S_ERR;
          error_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      to_cnt_d = '0;
    end else if (waiting) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end
  end

  // Outputs are decoded from the next state so the registered command lines
  // up with the registered state it belongs to.
  always_comb begin
    cmd_d   = CMD_NOP;
    data_d  = data_q;
    busy_d  = (state_d >= S_RST) && (state_d <= S_SORT);
    ready_d = (state_d == S_FILL);

    case (state_d)
      S_RST: begin
        cmd_d  = CMD_RST;
        data_d = '0;
      end
      S_FILL: begin
        if (accept) begin
          cmd_d  = CMD_FILL;
          data_d = center_in;
        end
      end
      S_FILLW: begin
        // The final accepted center is still forwarded on the edge that
        // enters FILLW; afterwards center_fill is held with zero data.
        cmd_d  = CMD_FILL;
        data_d = accept ? center_in : '0;
      end
      S_AXIS: begin
        cmd_d  = CMD_AXIS;
        data_d = DATA_W'(axis_d);
      end
      S_SORT: begin
        cmd_d  = CMD_SORT;
        data_d = DATA_W'(axis_d);
      end
      default: cmd_d = CMD_NOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      axis_q     <= '0;
      cmd_q      <= CMD_NOP;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      root_q     <= '0;
      ready_q    <= 1'b0;
      to_cnt_q   <= '0;
      fill_cnt_q <= '0;
      stab_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      axis_q     <= axis_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      root_q     <= root_d;
      ready_q    <= ready_d;
      to_cnt_q   <= to_cnt_d;
      fill_cnt_q <= fill_cnt_d;
      stab_cnt_q <= stab_cnt_d;
    end
  end

  assign center_in_ready = ready_q;
  assign data_to_root    = data_q;
  assign command_to_root = cmd_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;
  assign root_center     = root_q;
  assign state_out       = state_q;

endmodule

// File: tb/tb_kd_tree_root_ctrl.sv
// tb/tb_kd_tree_root_ctrl.sv - scoreboard bench for kd_tree_root_ctrl
module tb_kd_tree_root_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  axis;
  logic [23:0] center_in;
  logic        center_in_valid;
  logic        center_in_ready;
  logic [23:0] data_to_root;
  logic [4:0]  command_to_root;
  logic [23:0] data_from_root;
  logic [4:0]  command_from_root;
  logic        busy;
  logic        done;
  logic        error;
  logic [23:0] root_center;
  logic [2:0]  state_out;

  int compared = 0;
  int failed   = 0;
  int fill_cnt = 0;
  int stall_cnt = 0;

  logic [28:0] exp_ev[$];
  logic [23:0] exp_root[$];
  logic [28:0] prev_ev = '0;
  logic [28:0] cur_ev;
  logic [28:0] exp_v;
  logic [23:0] exp_r;

  kd_tree_root_ctrl #(
    .DATA_W(24), .CMD_W(5), .N_CENTERS(7), .AXIS_W(2),
    .TIMEOUT(20), .STABLE_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .axis(axis),
    .center_in(center_in), .center_in_valid(center_in_valid),
    .center_in_ready(center_in_ready),
    .data_to_root(data_to_root), .command_to_root(command_to_root),
    .data_from_root(data_from_root), .command_from_root(command_from_root),
    .busy(busy), .done(done), .error(error),
    .root_center(root_center), .state_out(state_out)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic void push_ev(input logic [4:0] c, input logic [23:0] d);
    exp_ev.push_back({c, d});
  endfunction

  function automatic logic [23:0] cen(input logic [7:0] b, input int i);
    logic [7:0] k;
    k = 8'(3 * i);
    return {b + k + 8'd1, b + k + 8'd2, b + k + 8'd3};
  endfunction

  // Monitor: every change of the (command, data) pair is one output event.
  always @(negedge clk) begin
    if (rst) begin
      prev_ev = '0;
    end else begin
      cur_ev = {command_to_root, data_to_root};
      if (cur_ev != prev_ev) begin
        if (exp_ev.size() == 0) begin
          compared++;
          failed++;
          $display("FAIL event_unexpected: actual=%h required=none", cur_ev);
        end else begin
          exp_v = exp_ev.pop_front();
          check("event", 32'(cur_ev), 32'(exp_v));
        end
        prev_ev = cur_ev;
      end
      if (done) begin
        if (exp_root.size() == 0) begin
          compared++;
          failed++;
          $display("FAIL done_unexpected: actual=%h required=none", root_center);
        end else begin
          exp_r = exp_root.pop_front();
          check("root_center", 32'(root_center), 32'(exp_r));
        end
      end
      if (command_to_root == 5'h01 && data_to_root != 24'h0) fill_cnt++;
      if (state_out == 3'd2 && command_to_root == 5'h00 && data_to_root != 24'h0) stall_cnt++;
    end
  end

  task automatic wait_out(input logic [4:0] c, input logic [23:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!(command_to_root == c && data_to_root == d) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      compared++;
      failed++;
      $display("FAIL wait_out: actual=%h/%h required=%h/%h", command_to_root, data_to_root, c, d);
    end
  endtask

  task automatic send_center(input logic [23:0] d);
    int n;
    n = 0;
    center_in = d;
    center_in_valid = 1'b1;
    @(negedge clk);
    while (!center_in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      compared++;
      failed++;
      $display("FAIL center_ready_wait: actual=0 required=1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] a);
    @(posedge clk); #1;
    start = 1'b1;
    axis  = a;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_resp(input int dly, input logic [4:0] code);
    repeat (dly) @(posedge clk);
    #1 command_from_root = code;
    @(posedge clk);
    #1 command_from_root = 5'h00;
  endtask

  task automatic sort_cycle(input logic [4:0] code);
    @(posedge clk);
    #1 command_from_root = code;
    @(negedge clk);
    check("done_early", 32'(done), 32'd0);
  endtask

  task automatic run_pass(input logic [1:0] a, input logic [7:0] base, input bit stall,
                          input bit unstable, input logic [23:0] root, input bit abort);
    int f0, s0;
    logic [23:0] ax;
    ax = {22'h0, a};
    push_ev(5'h1F, 24'h0);
    push_ev(5'h00, 24'h0);
    for (int i = 0; i < 7; i++) begin
      push_ev(5'h01, cen(base, i));
      if (stall && i == 2) push_ev(5'h00, cen(base, i));
    end
    push_ev(5'h01, 24'h0);
    push_ev(5'h02, ax);
    if (!abort) begin
      push_ev(5'h09, ax);
      push_ev(5'h00, ax);
      exp_root.push_back(root);
    end
    f0 = fill_cnt;
    s0 = stall_cnt;

    do_start(a);
    wait_out(5'h1F, 24'h0);
    pulse_resp(3, 5'h1E);
    for (int i = 0; i < 7; i++) begin
      send_center(cen(base, i));
      if (stall && i == 2) begin
        center_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
    end
    if (stall) center_in = 24'h999999;
    else center_in_valid = 1'b0;

    wait_out(5'h01, 24'h0);
    pulse_resp(5, 5'h05);
    center_in_valid = 1'b0;
    check("fill_count", 32'(fill_cnt - f0), 32'd7);
    check("stall_nops", 32'(stall_cnt - s0), stall ? 32'd3 : 32'd0);

    wait_out(5'h02, ax);
    if (abort) begin
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_state", 32'(state_out), 32'd0);
      check("abort_cmd", 32'(command_to_root), 32'h00);
      check("abort_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
    end else begin
      pulse_resp(2, 5'h07);
      wait_out(5'h09, ax);
      data_from_root = root;
      if (unstable) begin
        repeat (3) sort_cycle(5'h0A);
        sort_cycle(5'h08);
      end
      repeat (4) sort_cycle(5'h0A);
      @(posedge clk);
      #1 command_from_root = 5'h00;
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd1);
      check("done_state", 32'(state_out), 32'd6);
      check("done_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
      check("root_hold", 32'(root_center), 32'(root));
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    axis = 2'd0;
    center_in = 24'h0;
    center_in_valid = 1'b0;
    data_from_root = 24'h0;
    command_from_root = 5'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd", 32'(command_to_root), 32'h00);
    check("rst_data", 32'(data_to_root), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_root", 32'(root_center), 32'h0);
    check("rst_ready", 32'(center_in_ready), 32'd0);
    check("rst_state", 32'(state_out), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Nominal pass
    run_pass(2'd1, 8'h00, 1'b0, 1'b0, 24'hAABBCC, 1'b0);
    // Fill stall, 8th valid refused, sort instability
    run_pass(2'd2, 8'h20, 1'b1, 1'b1, 24'h445566, 1'b0);

    // Timeout in RST: no rst_done ever returned
    push_ev(5'h1F, 24'h0);
    push_ev(5'h00, 24'h0);
    do_start(2'd1);
    @(negedge clk);
    check("to_enter_rst", 32'(state_out), 32'd1);
    repeat (19) @(negedge clk);
    check("to_still_rst", 32'(state_out), 32'd1);
    @(negedge clk);
    check("to_state_err", 32'(state_out), 32'd7);
    check("to_error", 32'(error), 32'd1);
    check("to_cmd", 32'(command_to_root), 32'h00);
    check("to_busy", 32'(busy), 32'd0);
    push_ev(5'h1F, 24'h0);
    do_start(2'd2);
    @(negedge clk);
    check("recover_error", 32'(error), 32'd0);
    check("recover_state", 32'(state_out), 32'd1);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Abort during AXIS, then a full pass from IDLE
    run_pass(2'd3, 8'h40, 1'b0, 1'b0, 24'h0, 1'b1);
    run_pass(2'd1, 8'h60, 1'b0, 1'b0, 24'h123456, 1'b0);

    repeat (3) @(negedge clk);
    check("events_left", 32'(exp_ev.size()), 32'd0);
    check("roots_left", 32'(exp_root.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
